// File: rtl/vector_processor_core.sv
// Vector coprocessor core: runs one vector command at a time over BRAMs A and B,
// combines elements as the opcode asks, and streams each result LSB-first to the UART TX.
module vector_processor_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10,
   parameter int N_ELEM = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        cmd,
   input  logic              cmd_valid,
   input  logic [DATA_W-1:0] doutb_A,
   output logic              enb_A,
   output logic [ADDR_W-1:0] addrb_A,
   input  logic [DATA_W-1:0] doutb_B,
   output logic              enb_B,
   output logic [ADDR_W-1:0] addrb_B,
   input  logic              tx_ongoing,
   output logic              tx_start,
   output logic [7:0]        byte_to_send,
   output logic              coprocessor_busy,
   output logic              done
);

   localparam int NBYTES = (DATA_W + 7) / 8;
   localparam int RES_W  = NBYTES * 8;
   localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_ELEM - 1);
   localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(NBYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT_RD, S_SEND, S_TX_ACK, S_TX_BUSY
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP, OP_READ_A, OP_READ_B, OP_SUM, OP_AVG, OP_ABSDIFF
   } op_t;

   state_t            state, next_state;
   op_t               op;
   logic [ADDR_W-1:0] idx;
   logic [BI_W-1:0]   byte_idx;
   logic [RES_W-1:0]  result;
   logic [DATA_W-1:0] result_w;
   logic [DATA_W:0]   sum_w;
   logic [DATA_W-1:0] diff_w;
   logic              accept;
   logic              use_a, use_b;

   assign accept = (state == S_IDLE) && cmd_valid && (cmd inside {[3'd1:3'd5]});
   assign use_a  = (op != OP_READ_B);
   assign use_b  = (op != OP_READ_A);

   // Arithmetic is one bit wider than the element so the carry survives for SUM and AVG.
   assign sum_w  = {1'b0, doutb_A} + {1'b0, doutb_B};
   assign diff_w = (doutb_A >= doutb_B) ? (doutb_A - doutb_B) : (doutb_B - doutb_A);

   always_comb begin
      result_w = '0;
      case (op)
         OP_READ_A:  result_w = doutb_A;
         OP_READ_B:  result_w = doutb_B;
         OP_SUM:     result_w = sum_w[DATA_W] ? '1 : sum_w[DATA_W-1:0];
         OP_AVG:     result_w = sum_w[DATA_W:1];
         OP_ABSDIFF: result_w = diff_w;
         default:    result_w = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // NOTE: every output and next_state gets a default before the case, so no path can infer a latch.
   always_comb begin
      next_state   = state;
      enb_A        = 1'b0;
      enb_B        = 1'b0;
      tx_start     = 1'b0;
      case (state)
         S_IDLE:    if (accept) next_state = S_FETCH;
         S_FETCH: begin
            enb_A      = use_a;
            enb_B      = use_b;
            next_state = S_WAIT_RD;
         end
         S_WAIT_RD: next_state = S_SEND;
         S_SEND: begin
            if (!tx_ongoing) begin
               tx_start   = 1'b1;
               next_state = S_TX_ACK;
            end
         end
         S_TX_ACK:  if (tx_ongoing) next_state = S_TX_BUSY;
         S_TX_BUSY: begin
            if (!tx_ongoing) begin
               if (byte_idx != LAST_BYTE)  next_state = S_SEND;
               else if (idx != LAST_IDX)   next_state = S_FETCH;
               else                        next_state = S_IDLE;
            end
         end
         default:   next_state = S_IDLE;
      endcase
   end

   assign addrb_A          = enb_A ? idx : '0;
   assign addrb_B          = enb_B ? idx : '0;
   assign coprocessor_busy = (state != S_IDLE);
   // The payload is only driven while a byte is being handed to or held by the UART.
   assign byte_to_send     = (state inside {S_SEND, S_TX_ACK, S_TX_BUSY})
                             ? result[{byte_idx, 3'b000} +: 8] : 8'h00;

   // NOTE: the datapath registers are reset as well so that every output reads 0 straight out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         op       <= OP_NOP;
         idx      <= '0;
         byte_idx <= '0;
         result   <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op       <= op_t'(cmd);
                  idx      <= '0;
                  byte_idx <= '0;
               end
            end
            S_WAIT_RD: result <= RES_W'(result_w);
            S_TX_BUSY: begin
               if (!tx_ongoing) begin
                  if (byte_idx != LAST_BYTE) begin
                     byte_idx <= byte_idx + 1'b1;
                  end else if (idx != LAST_IDX) begin
                     idx      <= idx + 1'b1;
                     byte_idx <= '0;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/vector_processor_core.md
# vector_processor_core

Parametrised coprocessor core that executes one vector command at a time over two dual-port BRAMs (A and B) and streams results byte-by-byte to the UART transmitter. It generalises the single READ_A core in four ways:
- parametrised data width, address width and vector length;
- a second operand memory;
- element-wise arithmetic modes;
- explicit command-valid and done handshakes.

It sits between the command decoder, the BRAM B-ports and the UART TX.

## Interface
- DATA_W, 8, element width in bits (1..32); each element is sent as NBYTES = ceil(DATA_W/8) bytes.
- ADDR_W, 10, BRAM address width.
- N_ELEM, 1024, elements per command; 1 ≤ N_ELEM ≤ 2^ADDR_W.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd  in  3  opcodes: 0 NOP, 1 READ_A, 2 READ_B, 3 SUM, 4 AVG, 5 ABSDIFF; 6 and 7 are reserved.
- cmd_valid  in  1  qualifies cmd for one cycle.
- doutb_A  in  DATA_W  BRAM A read data; valid 1 cycle after enb_A/addrb_A.
- enb_A  out  1  BRAM A read enable.
- addrb_A  out  ADDR_W  BRAM A read address.
- doutb_B  in  DATA_W  BRAM B read data; same latency as A.
- enb_B  out  1  BRAM B read enable.
- addrb_B  out  ADDR_W  BRAM B read address.
- tx_ongoing  in  1  UART busy.
- tx_start  out  1  one-cycle pulse that starts a UART byte.
- byte_to_send  out  8  UART payload.
- coprocessor_busy  out  1  high while a command executes.
- done  out  1  one-cycle pulse after the last byte of a command completes.

## Operation
- States: IDLE, FETCH, WAIT_RD, SEND, TX_ACK, TX_BUSY.
- IDLE: a command is accepted when cmd_valid=1 and cmd is 1..5.
  - On accept, latch the opcode, set idx=0 and byte_idx=0, then go to FETCH.
  - NOP and reserved codes are ignored; the core stays in IDLE.
- FETCH: enb=1 and addrb=idx on the memories the opcode needs, then go to WAIT_RD.
  - READ_A uses A only; READ_B uses B only; SUM, AVG and ABSDIFF use both.
  - The enable of an unused memory stays 0.
- WAIT_RD: register result from doutb (one-cycle BRAM latency), then go to SEND. The arithmetic is done at DATA_W+1 bits:
  - READ_A: result = A.
  - READ_B: result = B.
  - SUM: A+B, saturated to 2^DATA_W−1.
  - AVG: floor((A+B)/2), carry included; no overflow.
  - ABSDIFF: |A−B|.
- SEND:
  - Drive byte_to_send = result[8*byte_idx +: 8], bits above DATA_W zero-padded. Bytes go out little-endian.
  - If tx_ongoing=0, pulse tx_start and go to TX_ACK; otherwise wait in SEND.
- TX_ACK: wait for tx_ongoing=1, then go to TX_BUSY.
- TX_BUSY: wait for tx_ongoing=0, then:
  - if byte_idx < NBYTES−1: byte_idx++, go to SEND;
  - else if idx < N_ELEM−1: idx++, byte_idx=0, go to FETCH;
  - else pulse done and go to IDLE.
- byte_to_send is held stable from tx_start until leaving TX_BUSY.
- cmd_valid outside IDLE is ignored; there is no queueing.
- idx never wraps: the last address used is N_ELEM−1.

## Timing
- Reset values: all outputs 0; state IDLE; idx=0; byte_idx=0.
- Reset mid-command: IDLE in the cycle after rst; busy drops. A UART byte already in flight is not aborted.
- Accept at cycle t: coprocessor_busy=1 and FETCH (enb high) at t+1; result registered at the end of t+2; earliest tx_start at t+3.
- coprocessor_busy is 1 in every non-IDLE state and 0 in IDLE, including the done cycle after the transition.
- done is asserted in the cycle the state returns to IDLE. A new cmd_valid is accepted in the cycle after done.
- tx_start is high for exactly one cycle per byte, never while tx_ongoing=1. Total pulses per command = N_ELEM·NBYTES.
- enb_A and enb_B are high for exactly one cycle per element.

## Test plan
- READ_A, N_ELEM=4, A=[11,22,33,44]h, UART model with tx_ongoing high 10 cycles after each tx_start -> bytes 11,22,33,44 in order; busy high from t+1 to done; one done pulse; enb_B never 1.
- SUM/AVG/ABSDIFF with A=F0h and B=20h -> 0xFF (saturated), 0x88, 0xD0. Also AVG with A=FFh, B=01h -> 0x80.
- cmd_valid=1 with READ_B during an active SUM, and with opcodes 0, 6 and 7 in IDLE -> ignored; output stream unchanged; busy stays low for the IDLE cases.
- tx_ongoing held high 200 cycles before the first byte -> core stays in SEND with no tx_start; exactly one tx_start after tx_ongoing falls.
- rst asserted while in TX_BUSY on element 2 -> next cycle all outputs 0 and state IDLE; a fresh READ_A restarts at address 0.
- DATA_W=12, A[0]=ABCh, READ_A -> bytes BCh then 0Ah; two tx_start pulses per element.
